// File: rtl/pingpong_tile_scheduler.sv
// Ping-pong tile buffer scheduler: fills one tile buffer from the loader while the
// compute array drains the other, swapping roles each tile until the job completes.
module pingpong_tile_scheduler #(
  parameter  int TILE_DEPTH  = 16,
  parameter  int NUM_TILES_W = 8,
  localparam int AW          = $clog2(TILE_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_TILES_W-1:0] num_tiles,
  output logic                   busy,
  output logic                   done,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  output logic                   ld_wr_en,
  output logic                   ld_buf_sel,
  output logic [AW-1:0]          ld_addr,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   rd_buf_sel,
  output logic [AW-1:0]          rd_addr,
  output logic                   rd_last,
  output logic [1:0]             buf_full
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | loading and draining tiles
  // DONE  | one-cycle job-complete pulse
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(TILE_DEPTH - 1);

  state_t                 state;
  logic [NUM_TILES_W-1:0] num_q;
  logic                   lp, rp;
  logic [AW-1:0]          ld_cnt, rd_cnt;
  logic [NUM_TILES_W:0]   tiles_loaded, tiles_read, tiles_read_nxt;
  logic                   run, rd_hs, ld_tile_done, rd_tile_done;

  assign run          = (state == RUN);
  assign busy         = run;
  assign done         = (state == DONE);
  assign ld_ready     = run & ~buf_full[lp] & (tiles_loaded < {1'b0, num_q});
  assign ld_wr_en     = ld_valid & ld_ready;
  assign ld_buf_sel   = lp;
  assign ld_addr      = ld_cnt;
  assign rd_valid     = run & buf_full[rp];
  assign rd_buf_sel   = rp;
  assign rd_addr      = rd_cnt;
  assign rd_last      = rd_valid & (rd_cnt == LAST_ADDR);
  assign rd_hs        = rd_valid & rd_ready;
  assign ld_tile_done = ld_wr_en & (ld_cnt == LAST_ADDR);
  assign rd_tile_done = rd_hs & rd_last;

  // Look ahead one tile so done follows the final read handshake by a single cycle.
  assign tiles_read_nxt = tiles_read + {{NUM_TILES_W{1'b0}}, rd_tile_done};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      num_q        <= '0;
      lp           <= 1'b0;
      rp           <= 1'b0;
      ld_cnt       <= '0;
      rd_cnt       <= '0;
      buf_full     <= 2'b00;
      tiles_loaded <= '0;
      tiles_read   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            num_q        <= num_tiles;
            lp           <= 1'b0;
            rp           <= 1'b0;
            ld_cnt       <= '0;
            rd_cnt       <= '0;
            buf_full     <= 2'b00;
            tiles_loaded <= '0;
            tiles_read   <= '0;
          end
        end
        RUN: begin
          if (ld_wr_en) begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_tile_done) begin
              buf_full[lp] <= 1'b1;
              lp           <= ~lp;
              tiles_loaded <= tiles_loaded + 1'b1;
            end
          end
          // lp and rp never name the same buffer while both a fill and a drain complete.
          if (rd_hs) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_tile_done) begin
              buf_full[rp] <= 1'b0;
              rp           <= ~rp;
              tiles_read   <= tiles_read_nxt;
            end
          end
          if (tiles_read_nxt == {1'b0, num_q}) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_tile_scheduler.sv
// Directed bench for pingpong_tile_scheduler: per-cycle scoreboard of load/read
// address sequences plus hand-computed cycle timings for each job scenario.
module tb_pingpong_tile_scheduler;
  localparam int TD = 16;
  localparam int NW = 8;
  localparam int AW = $clog2(TD);

  logic          clk = 1'b0;
  logic          rst_n, start, ld_valid, rd_ready;
  logic [NW-1:0] num_tiles;
  logic          busy, done, ld_ready, ld_wr_en, ld_buf_sel;
  logic [AW-1:0] ld_addr, rd_addr;
  logic          rd_valid, rd_buf_sel, rd_last;
  logic [1:0]    buf_full;

  pingpong_tile_scheduler #(.TILE_DEPTH(TD), .NUM_TILES_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
    .busy(busy), .done(done),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wr_en(ld_wr_en),
    .ld_buf_sel(ld_buf_sel), .ld_addr(ld_addr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_buf_sel(rd_buf_sel),
    .rd_addr(rd_addr), .rd_last(rd_last), .buf_full(buf_full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outs"}, {busy, done, ld_ready, ld_wr_en, ld_buf_sel, ld_addr,
                          rd_valid, rd_buf_sel, rd_addr, rd_last}, 0);
    check({tag, "_buf_full"}, buf_full, 0);
  endtask

  int first_rd_cyc, first_last_cyc, done_cyc, ld_resume_cyc;
  int overlap, nld, nrd, n_done;

  // Runs one job; start at cycle 0. rd_ready is held low for cyc < stall_until.
  // With poke set, a second start (num_tiles=9) is pulsed mid-job and must be ignored.
  task automatic run_job(input int n, input bit rand_ld, input int stall_until, input bit poke);
    int  t;
    bit  fin;
    nld = 0; nrd = 0; n_done = 0; overlap = 0;
    first_rd_cyc = -1; first_last_cyc = -1; done_cyc = -1; ld_resume_cyc = -1;
    fin = 1'b0;
    for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
      @(negedge clk);
      start     = (cyc == 0) || (poke && cyc == 5);
      num_tiles = (cyc == 0) ? n[NW-1:0] : 8'd9;
      ld_valid  = rand_ld ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_ready  = (cyc >= stall_until);
      #1;
      if (stall_until > 0 && cyc == stall_until - 5) begin
        check("bp_buf_full", buf_full, 3);
        check("bp_ld_ready", ld_ready, 0);
      end
      if (rd_valid) begin
        t = nrd / TD;
        check("rd_valid_on_full_buf", 32'(nld >= TD * (t + 1)), 1);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (rd_ready) begin
          check("rd_addr", rd_addr, nrd % TD);
          check("rd_buf_sel", rd_buf_sel, t % 2);
          check("rd_last", rd_last, 32'((nrd % TD) == TD - 1));
          if (rd_last && first_last_cyc < 0) first_last_cyc = cyc;
          if (ld_wr_en) overlap++;
          nrd++;
        end
      end
      if (ld_wr_en) begin
        check("ld_addr", ld_addr, nld % TD);
        check("ld_buf_sel", ld_buf_sel, (nld / TD) % 2);
        nld++;
      end
      if (ld_ready && cyc >= stall_until && ld_resume_cyc < 0) ld_resume_cyc = cyc;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) fin = 1'b1;
    end
    if (!fin) check("job_timeout", 0, 1);
    check("end_busy", busy, 0);
    check("end_done", done, 0);
    check("ld_count", nld, TD * n);
    check("rd_count", nrd, TD * n);
    check("done_pulses", n_done, 1);
    start = 1'b0; ld_valid = 1'b0; rd_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ld_valid = 1'b0; rd_ready = 1'b0; num_tiles = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Single tile, continuous handshakes.
    run_job(1, 1'b0, 0, 1'b0);
    check("t1_first_rd", first_rd_cyc, 17);
    check("t1_rd_last", first_last_cyc, 32);
    check("t1_done", done_cyc, 33);
    check("t1_overlap", overlap, 0);

    // Four tiles, loads of tile n+1 overlap reads of tile n.
    run_job(4, 1'b0, 0, 1'b0);
    check("t4_first_rd", first_rd_cyc, 17);
    check("t4_done", done_cyc, 81);
    check("t4_overlap", overlap, 48);

    // Reader backpressure until cycle 40.
    run_job(3, 1'b0, 40, 1'b0);
    check("bp_first_rd", first_rd_cyc, 17);
    check("bp_rd_last", first_last_cyc, 55);
    check("bp_ld_resume", ld_resume_cyc, 56);
    check("bp_done", done_cyc, 88);

    // Random loader stalls.
    run_job(3, 1'b1, 0, 1'b0);

    // Empty job.
    run_job(0, 1'b0, 0, 1'b0);
    check("t0_done", done_cyc, 2);
    check("t0_first_rd", first_rd_cyc, -1);

    // Start while busy ignored.
    run_job(1, 1'b0, 0, 1'b1);
    check("poke_done", done_cyc, 33);

    // Reset mid-job, then a fresh job.
    @(negedge clk);
    start = 1'b1; num_tiles = 8'd2; ld_valid = 1'b1; rd_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    run_job(1, 1'b0, 0, 1'b0);
    check("post_reset_done", done_cyc, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
